// File: rtl/bp_pkg.sv
// Shared types, opcode/counter constants and immediate decoders for the
// gshare branch predictor.
package bp_pkg;

  // Widest address the immediate helpers produce; callers truncate to XLEN.
  localparam int MAX_XLEN = 64;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  typedef enum logic {INIT, RUN} bp_state_e;

  // J-type immediate from instruction bits [31:12], sign-extended.
  function automatic logic [MAX_XLEN-1:0] imm_j(input logic [31:12] ih);
    logic [20:0] imm;
    imm = {ih[31], ih[19:12], ih[20], ih[30:21], 1'b0};
    return {{(MAX_XLEN-21){imm[20]}}, imm};
  endfunction

  // B-type immediate from instruction bits [31:25] and [11:7], sign-extended.
  function automatic logic [MAX_XLEN-1:0] imm_b(input logic [31:25] hi,
                                                input logic [11:7]  lo);
    logic [12:0] imm;
    imm = {hi[31], lo[7], hi[30:25], lo[11:8], 1'b0};
    return {{(MAX_XLEN-13){imm[12]}}, imm};
  endfunction

  // Two-bit saturating counter step.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    case (c)
      SNT:     return taken ? WNT : SNT;
      WNT:     return taken ? WT  : SNT;
      WT:      return taken ? ST  : WNT;
      default: return taken ? ST  : WT;
    endcase
  endfunction

endpackage

// File: rtl/bp_gshare_if.sv
// Fetch-side lookup bus, prediction results and backend training/repair
// signals of the gshare predictor.
interface bp_gshare_if #(
  parameter int FETCH_W = 8,
  parameter int XLEN    = 64,
  parameter int GHR_W   = 10
);

  // Fetch block in
  logic                 if_valid;
  logic                 if_stall;
  logic [XLEN-1:0]      if_adderss;
  logic [FETCH_W*32-1:0] if_data;

  // Prediction out
  logic                 out_valid;
  logic [FETCH_W-1:0]   if_inst_out;
  logic [FETCH_W-1:0]   bp_if;
  logic [XLEN-1:0]      next_pc;
  logic [GHR_W-1:0]     bp_ghr;
  logic                 ready;

  // Backend resolution in
  logic                 jump_start;
  logic [XLEN-1:0]      jump_inst;
  logic                 jump_taken;
  logic                 jump_mispredict;
  logic [GHR_W-1:0]     jump_ghr;

  modport master (
    output if_valid, if_stall, if_adderss, if_data,
    output jump_start, jump_inst, jump_taken, jump_mispredict, jump_ghr,
    input  out_valid, if_inst_out, bp_if, next_pc, bp_ghr, ready
  );

  modport slave (
    input  if_valid, if_stall, if_adderss, if_data,
    input  jump_start, jump_inst, jump_taken, jump_mispredict, jump_ghr,
    output out_valid, if_inst_out, bp_if, next_pc, bp_ghr, ready
  );

endinterface

// File: rtl/bht_ram.sv
// Counter table: RD_PORTS combinational reads of the taken bit, one write
// port shared by the init sweep (priority) and saturating training updates.
module bht_ram import bp_pkg::*; #(
  parameter int DEPTH    = 1024,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int RD_PORTS = 8
) (
  input  logic                          clk,
  input  logic [RD_PORTS-1:0][IDX_W-1:0] rd_idx,
  output logic [RD_PORTS-1:0]           rd_taken,
  input  logic                          init_en,
  input  logic [IDX_W-1:0]              init_idx,
  input  logic                          upd_en,
  input  logic [IDX_W-1:0]              upd_idx,
  input  logic                          upd_taken
);

  ctr_t mem [DEPTH];

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  ctr_t             wr_data;

  // Read the prediction bit of every requested entry.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rd_taken = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      rd_taken[k] = mem[rd_idx[k]][1];
    end
  end

  // Single write port: the init sweep wins over a training update.
  always_comb begin
    wr_en   = init_en || upd_en;
    wr_idx  = init_en ? init_idx : upd_idx;
    wr_data = init_en ? WNT : ctr_next(mem[upd_idx], upd_taken);
  end

  // Counter storage write; reads in the same cycle see the old contents.
  // NOTE: the array has no reset -- the init sweep clears it, keeping it mappable to RAM; state updates use <= so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

endmodule

// File: rtl/bp_gshare.sv
// Gshare predictor: scans a fetch block for JAL / conditional branches,
// indexes the counter table with PC ^ GHR, registers slot mask, taken slot
// and next PC, and repairs the speculative history on a mispredict.
module bp_gshare import bp_pkg::*; #(
  parameter int  FETCH_W   = 8,
  parameter int  XLEN      = 64,
  parameter int  BHT_DEPTH = 1024,
  parameter int  GHR_W     = 10,
  localparam int IDX_W     = $clog2(BHT_DEPTH)
) (
  input logic       clk,
  input logic       reset,
  bp_gshare_if.slave bus
);

  localparam int OFF_W   = $clog2(FETCH_W);
  localparam int BLK_LSB = OFF_W + 2;

  // FSM / sweep
  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] sweep_ptr_q;
  logic             sweep_en;
  logic             run_mode;

  // History and block geometry
  logic [GHR_W-1:0]               ghr_q;
  logic [XLEN-1:0]                base;
  logic [XLEN-1:0]                fall_pc;
  logic [OFF_W-1:0]               start;
  logic [FETCH_W-1:0][XLEN-1:0]   slot_pc;
  logic [FETCH_W-1:0][IDX_W-1:0]  rd_idx;
  logic [FETCH_W-1:0]             ctr_taken;
  logic [IDX_W-1:0]               upd_idx;

  // Scan result
  logic               found;
  logic               win_br;
  logic               any_br;
  logic [OFF_W-1:0]   win;
  logic [XLEN-1:0]    target;
  logic [FETCH_W-1:0] slot_mask;
  logic [FETCH_W-1:0] bp_mask;

  // Control
  logic accept;
  logic upd_en;
  logic repair;

  // Output registers
  logic               out_valid_q;
  logic [FETCH_W-1:0] inst_out_q;
  logic [FETCH_W-1:0] bp_if_q;
  logic [XLEN-1:0]    next_pc_q;
  logic [GHR_W-1:0]   bp_ghr_q;

  // Address bits that never influence prediction.
  logic unused_bits;
  assign unused_bits = ^{bus.if_adderss[1:0], bus.jump_inst[1:0],
                         bus.jump_inst[XLEN-1:IDX_W+2]};

  assign base    = {bus.if_adderss[XLEN-1:BLK_LSB], {BLK_LSB{1'b0}}};
  assign start   = bus.if_adderss[BLK_LSB-1:2];
  assign fall_pc = base + XLEN'(FETCH_W * 4);

  assign accept  = run_mode && bus.if_valid && !bus.if_stall;
  assign upd_en  = run_mode && bus.jump_start;
  assign repair  = upd_en && bus.jump_mispredict;
  assign upd_idx = bus.jump_inst[IDX_W+1:2] ^ IDX_W'(bus.jump_ghr);

  // ---------------------------------------------------------------- FSM

  // State register: reset (also mid-sweep) restarts in INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= INIT;
    else       state_q <= state_d;
  end

  // Sweep pointer walks every table entry once while in INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         sweep_ptr_q <= '0;
    else if (sweep_en) sweep_ptr_q <= sweep_ptr_q + 1'b1;
  end

  // Next state: leave INIT after the last entry has been written.
  always_comb begin
    state_d = state_q;
    if (state_q == INIT && sweep_ptr_q == IDX_W'(BHT_DEPTH - 1)) state_d = RUN;
  end

  // FSM outputs: sweep enable and lookup/update gating.
  always_comb begin
    sweep_en = (state_q == INIT);
    run_mode = (state_q == RUN);
  end

  // ---------------------------------------------------------------- table

  // Slot PCs stay inside the block; table index mixes PC with history.
  always_comb begin
    slot_pc = '0;
    rd_idx  = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      slot_pc[k] = {base[XLEN-1:BLK_LSB], OFF_W'(k), 2'b00};
      rd_idx[k]  = slot_pc[k][IDX_W+1:2] ^ IDX_W'(ghr_q);
    end
  end

  bht_ram #(
    .DEPTH   (BHT_DEPTH),
    .IDX_W   (IDX_W),
    .RD_PORTS(FETCH_W)
  ) u_bht (
    .clk      (clk),
    .rd_idx   (rd_idx),
    .rd_taken (ctr_taken),
    .init_en  (sweep_en),
    .init_idx (sweep_ptr_q),
    .upd_en   (upd_en),
    .upd_idx  (upd_idx),
    .upd_taken(bus.jump_taken)
  );

  // ---------------------------------------------------------------- scan

  // First taken slot at or after start wins; not-taken branches only feed history.
  always_comb begin
    found  = 1'b0;
    win_br = 1'b0;
    any_br = 1'b0;
    win    = '0;
    target = fall_pc;
    for (int k = 0; k < FETCH_W; k++) begin
      if (!found && OFF_W'(k) >= start) begin
        if (bus.if_data[32*k +: 7] == OP_JAL) begin
          found  = 1'b1;
          win    = OFF_W'(k);
          target = slot_pc[k] + XLEN'(imm_j(bus.if_data[32*k+12 +: 20]));
        end else if (bus.if_data[32*k +: 7] == OP_BRANCH) begin
          any_br = 1'b1;
          if (ctr_taken[k]) begin
            found  = 1'b1;
            win_br = 1'b1;
            win    = OFF_W'(k);
            target = slot_pc[k] + XLEN'(imm_b(bus.if_data[32*k+25 +: 7],
                                               bus.if_data[32*k+7 +: 5]));
          end
        end
      end
    end
  end

  // Forwarded slots run from start up to the winner; one-hot taken slot.
  always_comb begin
    slot_mask = '0;
    bp_mask   = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      if (OFF_W'(k) >= start && (!found || OFF_W'(k) <= win)) slot_mask[k] = 1'b1;
    end
    if (found) bp_mask[win] = 1'b1;
  end

  // ---------------------------------------------------------------- state

  // Global history: mispredict repair overrides the speculative shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 ghr_q <= '0;
    else if (repair)           ghr_q <= {bus.jump_ghr[GHR_W-2:0], bus.jump_taken};
    else if (accept && any_br) ghr_q <= {ghr_q[GHR_W-2:0], win_br};
  end

  // Result registers: frozen by stall, squashed by a mispredict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      inst_out_q  <= '0;
      bp_if_q     <= '0;
      next_pc_q   <= '0;
      bp_ghr_q    <= '0;
    end else if (!bus.if_stall) begin
      out_valid_q <= accept && !repair;
      if (accept) begin
        inst_out_q <= slot_mask;
        bp_if_q    <= bp_mask;
        next_pc_q  <= target;
        bp_ghr_q   <= ghr_q;
      end
    end else if (repair) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.if_inst_out = inst_out_q;
  assign bus.bp_if       = bp_if_q;
  assign bus.next_pc     = next_pc_q;
  assign bus.bp_ghr      = bp_ghr_q;
  assign bus.ready       = run_mode;

endmodule

// File: tb/tb_bp_gshare.sv
// Directed scoreboard bench for bp_gshare: init sweep timing, lookups,
// training, stall hold, mispredict repair and address wrap.
module tb_bp_gshare;

  localparam int FW    = 8;
  localparam int XL    = 64;
  localparam int GW    = 10;
  localparam int DEPTH = 1024;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bp_gshare_if #(.FETCH_W(FW), .XLEN(XL), .GHR_W(GW)) bus ();

  bp_gshare #(.FETCH_W(FW), .XLEN(XL), .BHT_DEPTH(DEPTH), .GHR_W(GW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string         tag;
    logic          valid;
    logic [FW-1:0] inst;
    logic [FW-1:0] bpif;
    logic [XL-1:0] npc;
    logic [GW-1:0] ghr;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [FW*32-1:0] blk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_jal(input int imm);
    logic [20:0] i;
    i = imm[20:0];
    return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_br(input int imm, input logic [2:0] f3);
    logic [12:0] i;
    i = imm[12:0];
    return {i[12], i[10:5], 5'd2, 5'd1, f3, i[4:1], i[11], 7'b1100011};
  endfunction

  task automatic nop_blk();
    for (int k = 0; k < FW; k++) blk[32*k +: 32] = NOP;
  endtask

  task automatic set_lookup(input logic [XL-1:0] addr);
    bus.if_valid   = 1'b1;
    bus.if_adderss = addr;
    bus.if_data    = blk;
  endtask

  task automatic push_exp(input string tag, input logic v, input logic [FW-1:0] inst,
                          input logic [FW-1:0] bpif, input logic [XL-1:0] npc,
                          input logic [GW-1:0] g);
    exp_t e;
    e.tag = tag; e.valid = v; e.inst = inst; e.bpif = bpif; e.npc = npc; e.ghr = g;
    sb.push_back(e);
  endtask

  // One clock: sample the registered result, compare with the oldest expectation,
  // then drop all one-shot stimulus.
  task automatic tick_and_check();
    exp_t e;
    @(posedge clk);
    #1;
    n_checks++;
    assert (sb.size() > 0)
    else begin
      n_fail++;
      $error("FAIL sb_underflow: observed empty expected entry");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".out_valid"}, bus.out_valid, e.valid);
      if (e.valid) begin
        check({e.tag, ".if_inst_out"}, bus.if_inst_out, e.inst);
        check({e.tag, ".bp_if"},       bus.bp_if,       e.bpif);
        check({e.tag, ".next_pc"},     bus.next_pc,     e.npc);
        check({e.tag, ".bp_ghr"},      bus.bp_ghr,      e.ghr);
      end
    end
    bus.if_valid        = 1'b0;
    bus.if_stall        = 1'b0;
    bus.jump_start      = 1'b0;
    bus.jump_mispredict = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int early;
    int cycles;
    int bad;

    reset               = 1'b1;
    bus.if_valid        = 1'b0;
    bus.if_stall        = 1'b0;
    bus.if_adderss      = '0;
    bus.if_data         = '0;
    bus.jump_start      = 1'b0;
    bus.jump_inst       = '0;
    bus.jump_taken      = 1'b0;
    bus.jump_mispredict = 1'b0;
    bus.jump_ghr        = '0;
    nop_blk();
    set_lookup(64'h1000);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.out_valid",   bus.out_valid,   0);
    check("rst.if_inst_out", bus.if_inst_out, 0);
    check("rst.bp_if",       bus.bp_if,       0);
    check("rst.next_pc",     bus.next_pc,     0);
    check("rst.bp_ghr",      bus.bp_ghr,      0);
    check("rst.ready",       bus.ready,       0);
    reset = 1'b0;

    // Part of a sweep, then reset mid-sweep
    early = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready || bus.out_valid) early++;
    end
    check("sweep500.early_activity", early, 0);
    reset = 1'b1;
    #1;
    check("reset_mid_sweep.ready", bus.ready, 0);
    @(negedge clk);
    reset = 1'b0;

    // Full sweep from zero with if_valid held high
    cycles = 0;
    bad    = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.out_valid) bad++;
    end while (!bus.ready && cycles < 2000);
    check("init.cycles_to_ready", cycles, DEPTH);
    check("init.out_valid_low",   bad,    0);
    bus.if_valid = 1'b0;

    // Idle after init
    push_exp("idle0", 1'b0, '0, '0, '0, '0);
    tick_and_check();

    // JAL +0x40 in slot 3
    nop_blk();
    blk[3*32 +: 32] = enc_jal(32'h40);
    set_lookup(64'h1000);
    push_exp("jal_slot3", 1'b1, 8'h0F, 8'h08, 64'h104C, 10'h000);
    tick_and_check();

    // Mid-block start, no branches
    nop_blk();
    set_lookup(64'h1008);
    push_exp("mid_block_nobr", 1'b1, 8'hFC, 8'h00, 64'h1020, 10'h000);
    tick_and_check();

    // Train BEQ at 0x2004 taken twice under GHR=0
    for (int t = 0; t < 2; t++) begin
      bus.jump_start      = 1'b1;
      bus.jump_inst       = 64'h2004;
      bus.jump_taken      = 1'b1;
      bus.jump_ghr        = 10'h000;
      bus.jump_mispredict = 1'b0;
      push_exp("train", 1'b0, '0, '0, '0, '0);
      tick_and_check();
    end

    // Trained BEQ imm=-8 in slot 1
    nop_blk();
    blk[1*32 +: 32] = enc_br(-8, 3'b000);
    set_lookup(64'h2000);
    push_exp("beq_trained", 1'b1, 8'h03, 8'h02, 64'h1FFC, 10'h000);
    tick_and_check();

    // Not-taken branch in slot 1, JAL +0x100 in slot 5 (GHR now 1)
    nop_blk();
    blk[1*32 +: 32] = enc_br(32, 3'b001);
    blk[5*32 +: 32] = enc_jal(32'h100);
    set_lookup(64'h3000);
    push_exp("nt_then_jal", 1'b1, 8'h3F, 8'h20, 64'h3114, 10'h001);
    tick_and_check();

    // Stalled lookup holding a branch: outputs and GHR frozen
    nop_blk();
    blk[0*32 +: 32] = enc_br(16, 3'b000);
    set_lookup(64'h5000);
    bus.if_stall = 1'b1;
    push_exp("stall_hold", 1'b1, 8'h3F, 8'h20, 64'h3114, 10'h001);
    tick_and_check();

    // History after the JAL block shifted in a 0
    nop_blk();
    set_lookup(64'h4004);
    push_exp("after_stall", 1'b1, 8'hFE, 8'h00, 64'h4020, 10'h002);
    tick_and_check();

    // Start at slot 7; branch in slot 0 is below start and ignored
    nop_blk();
    blk[0*32 +: 32] = enc_br(16, 3'b000);
    set_lookup(64'h401C);
    push_exp("start_slot7", 1'b1, 8'h80, 8'h00, 64'h4020, 10'h002);
    tick_and_check();

    nop_blk();
    set_lookup(64'h4000);
    push_exp("ignored_branch_no_shift", 1'b1, 8'hFF, 8'h00, 64'h4020, 10'h002);
    tick_and_check();

    // Lookup with a branch concurrent with a mispredict repair
    nop_blk();
    blk[2*32 +: 32] = enc_br(16, 3'b000);
    set_lookup(64'h6000);
    bus.jump_start      = 1'b1;
    bus.jump_mispredict = 1'b1;
    bus.jump_taken      = 1'b1;
    bus.jump_ghr        = 10'h155;
    bus.jump_inst       = 64'h8000;
    push_exp("mispredict_squash", 1'b0, '0, '0, '0, '0);
    tick_and_check();

    nop_blk();
    set_lookup(64'h1000);
    push_exp("ghr_repaired", 1'b1, 8'hFF, 8'h00, 64'h1020, 10'h2AB);
    tick_and_check();

    // Target wraps modulo 2^64
    nop_blk();
    blk[7*32 +: 32] = enc_jal(32'h40);
    set_lookup(64'hFFFF_FFFF_FFFF_FFE0);
    push_exp("target_wrap", 1'b1, 8'hFF, 8'h80, 64'h3C, 10'h2AB);
    tick_and_check();

    push_exp("idle_end", 1'b0, '0, '0, '0, '0);
    tick_and_check();

    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
